fixed_alu_gen: RTL and testbench
================================

FIXED_ALU_GEN -- requirements
Module: fixed_alu_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width in bits (signed two's complement).
REQ-002 The block SHALL have parameter FRAC, default 14, meaning the number of fraction bits (Q(WIDTH-FRAC).FRAC), constrained to 0 < FRAC < WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 1, where 1 clamps out-of-range results to MAX/MIN and 0 wraps them.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand/opcode presented.
REQ-007 in_ready  output  1  block accepts a request; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-008 operand_a, operand_b  input  WIDTH  signed Q operands.
REQ-009 operation  input  4  opcode, using the shared ALU opcode set: ADD SUB MUL DIV MOD AND OR XOR SHL SHR ABS NEG CMP MIN MAX.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts; transfer on an edge where out_valid and out_ready are both 1.
REQ-012 result  output  WIDTH  Q-format result.
REQ-013 overflow, div_by_zero  output  1 each  status flags qualified by out_valid.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, DIV_ITER and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on input transfer, operands/opcode SHALL be registered; DIV/MOD with operand_b != 0 -> DIV_ITER, otherwise -> EXEC.
REQ-016 EXEC: result/flags SHALL be registered in one cycle -> HOLD; latency is 2 edges from acceptance to out_valid=1.
REQ-017 DIV_ITER: unsigned restoring division SHALL run exactly WIDTH+FRAC iterations, one per cycle, then -> HOLD; latency WIDTH+FRAC+2 edges (48 at defaults).
REQ-018 DIV SHALL compute (|a|<<FRAC)/|b|, negated if signs differ; MOD SHALL compute |a| mod |b| on raw values, taking the sign of a.
REQ-019 DIV or MOD with b==0 SHALL take the EXEC path with div_by_zero=1; DIV result MAX if a>=0, else MIN; MOD result a.
REQ-020 HOLD: out_valid=1; result/flags SHALL stay stable until output transfer, then -> IDLE; an operation is never dropped or duplicated.
REQ-021 ADD/SUB SHALL compute at WIDTH+1 bits; overflow=1 when the true result exceeds the signed WIDTH range.
REQ-022 MUL SHALL form the 2*WIDTH signed product, arithmetic-shift right by FRAC (truncate toward -inf), and set overflow if it does not fit WIDTH.
REQ-023 ABS/NEG of MIN SHALL set overflow=1.
REQ-024 With SATURATE=1, every overflowing result SHALL be MAX (0x7FFFFFFF at defaults) for positive true values or MIN for negative; with SATURATE=0, the low WIDTH bits SHALL be kept; overflow is flagged in both modes.
REQ-025 SHL/SHR SHALL use operand_b[$clog2(WIDTH)-1:0] as the amount; SHR is arithmetic; SHL never flags overflow.
REQ-026 CMP, MIN and MAX SHALL use signed comparison; CMP returns +1.0, 0 or -1.0 in Q format (0x00004000 / 0 / 0xFFFFC000 at defaults).
REQ-027 AND/OR/XOR SHALL be bitwise; undefined opcodes SHALL return 0 with no flags set.
REQ-028 Flags SHALL be cleared on every new acceptance and SHALL not carry over between operations.

Reset
REQ-029 Asserting reset_n=0 at any time, including mid-DIV_ITER or in HOLD, SHALL immediately abort the current operation and return to IDLE.
REQ-030 During reset, in_ready=0 and out_valid=0, and result, overflow and div_by_zero SHALL all be 0; in_ready SHALL rise on the first edge after release.

Structure
REQ-031 Package fixed_alu_pkg SHALL hold opcode constants, the FSM state encoding, and Q-format MAX/MIN/ONE constants as functions of WIDTH/FRAC.
REQ-032 The iterative divider SHALL be the sub-module fixed_div_iter, with ports start, busy, done, dividend, divisor, quotient, remainder and parameter ITER=WIDTH+FRAC.

Verification (defaults)
REQ-033 MUL 0x00006000 (1.5) x 0x00008000 (2.0) -> result 0x0000C000, overflow 0, out_valid 2 edges after acceptance.
REQ-034 DIV 0x0000C000 / 0x00008000 -> 0x00006000 after 48 edges; DIV 0xFFFF4000 (-3.0) / 0x00008000 -> 0xFFFFA000.
REQ-035 ADD 0x7FFFFFFF + 0x00004000 -> 0x7FFFFFFF with overflow 1 (SATURATE=1); -> 0x80003FFF with overflow 1 (SATURATE=0); NEG 0x80000000 -> 0x7FFFFFFF, overflow 1.
REQ-036 DIV 0x00004000 / 0 -> 0x7FFFFFFF, div_by_zero 1, latency 2; MOD 0x00005000 / 0 -> 0x00005000, div_by_zero 1.
REQ-037 Hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready 0 throughout, exactly one transfer each way after release.
REQ-038 Assert reset_n=0 at iteration 20 of a DIV -> out_valid 0 and all outputs 0 immediately; a following ADD 0x4000+0x4000 -> 0x00008000 correct.

Source files
------------

// File: rtl/fixed_alu_pkg.sv
// Shared definitions for the fixed-point ALU.
// Contents: ALU opcode constants, FSM state encoding, and Q-format
// MAX/MIN/ONE constants.
// The Q-format helpers return 64-bit values, so WIDTH is limited to 64.
package fixed_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ABS = 4'd10;
  localparam logic [3:0] OP_NEG = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam logic [3:0] OP_MIN = 4'd13;
  localparam logic [3:0] OP_MAX = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_DIV_ITER = 2'd2,
    S_HOLD     = 2'd3
  } state_e;

  // Largest positive value of a w-bit two's-complement word.
  function automatic logic [63:0] q_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value; the low w bits are 1000...0.
  function automatic logic [63:0] q_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // +1.0 in a format that has f fraction bits.
  function automatic logic [63:0] q_one(input int f);
    return 64'd1 << f;
  endfunction

endpackage

// File: rtl/fixed_div_iter.sv
// Unsigned restoring divider that produces one quotient bit per cycle.
// Ports:
//   start     : loads dividend and divisor. Iteration begins on the next edge.
//   busy      : high from start until the cycle after done.
//   done      : high for one cycle once all ITER iterations are complete.
//               quotient and remainder are valid while done is high.
//   dividend  : ITER bits.
//   divisor   : WIDTH bits. Must be nonzero.
//   quotient  : ITER bits.
//   remainder : WIDTH bits.
module fixed_div_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH + 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [ITER-1:0]  dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [ITER-1:0]  quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(ITER + 1);

  logic [CW-1:0]    cnt_q;
  logic [ITER-1:0]  quo_q;
  logic [WIDTH-1:0] rem_q, dvs_q;
  logic             busy_q;
  logic [WIDTH:0]   shift_w, trial_w;

  // The partial remainder is always below the divisor.
  // Shifting it left by one therefore fits in WIDTH+1 bits.
  // A set MSB in trial_w means the subtraction went negative,
  // so the shifted value is restored.
  always_comb begin
    shift_w = {rem_q, quo_q[ITER-1]};
    trial_w = shift_w - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= CW'(ITER);
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        quo_q <= {quo_q[ITER-2:0], ~trial_w[WIDTH]};
        rem_q <= trial_w[WIDTH] ? shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/fixed_alu_gen.sv
// Signed fixed-point ALU. Operands use the Q(WIDTH-FRAC).FRAC format.
// Input and output use valid/ready handshakes.
// Ports:
//   in_valid / in_ready        : request handshake (ready only in IDLE).
//   operand_a, operand_b       : signed Q operands.
//   operation                  : 4-bit opcode.
//   out_valid / out_ready      : response handshake.
//   result                     : Q result.
//   overflow, div_by_zero      : status flags, qualified by out_valid.
// Behaviour:
//   Most opcodes produce a result one cycle after acceptance.
//   DIV and MOD with a nonzero divisor use the iterative divider.
//   Overflowing results saturate when SATURATE is nonzero; otherwise they wrap.
module fixed_alu_gen
  import fixed_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 14,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] operand_a,
  input  logic signed [WIDTH-1:0] operand_b,
  input  logic [3:0]              operation,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    overflow,
  output logic                    div_by_zero
);
  localparam int ITER = WIDTH + FRAC;
  // Wide enough for the full product and the divider quotient,
  // with headroom for the range check.
  localparam int XW   = 2 * WIDTH + 2;
  localparam int SHW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(q_max(WIDTH));
  localparam logic [WIDTH-1:0] QMIN = WIDTH'(q_min(WIDTH));
  localparam logic [WIDTH-1:0] QONE = WIDTH'(q_one(FRAC));

  state_e                  state_q, state_d;
  logic                    rdy_q;
  logic [3:0]              op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        res_q;
  logic                    ovf_q, dbz_q;

  logic                    accept, is_div, div_start;
  logic                    div_busy, div_done;
  logic [WIDTH-1:0]        abs_a, abs_b;
  logic [ITER-1:0]         div_dvd, div_quo;
  logic [WIDTH-1:0]        div_rem;
  logic                    div_neg;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [XW-1:0]      wv;
  logic signed [WIDTH-1:0]   rw;
  logic                      narrow, dbz_w, ovf_w;
  logic [WIDTH-1:0]          res_w;

  // rdy_q keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = rdy_q && (state_q == S_IDLE) && !div_busy;
  assign out_valid = (state_q == S_HOLD);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign div_by_zero = dbz_q;

  assign accept    = in_valid && in_ready;
  assign is_div    = (operation == OP_DIV) || (operation == OP_MOD);
  assign div_start = accept && is_div && (operand_b != '0);

  // The divider loads straight from the ports on the acceptance edge.
  // This lets its ITER iterations overlap the DIV_ITER state exactly.
  // The magnitude of MIN is 100..0, which is correct read as unsigned.
  assign abs_a   = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b   = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign div_dvd = (operation == OP_DIV) ? {abs_a, {FRAC{1'b0}}} : ITER'(abs_a);
  assign div_neg = (op_q == OP_DIV) ? (a_q[WIDTH-1] ^ b_q[WIDTH-1]) : a_q[WIDTH-1];

  fixed_div_iter #(.WIDTH(WIDTH), .ITER(ITER)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (abs_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign prod = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);

  // Every opcode first forms its true value at XW bits.
  // A single range check then yields overflow and the saturated or wrapped result.
  // Opcodes that cannot overflow produce a WIDTH-bit rw, which is sign-extended.
  always_comb begin
    wv     = '0;
    rw     = '0;
    narrow = 1'b0;
    dbz_w  = 1'b0;
    if (state_q == S_DIV_ITER) begin
      wv = (op_q == OP_MOD) ? XW'(div_rem) : XW'(div_quo);
      if (div_neg) wv = -wv;
    end else begin
      case (op_q)
        OP_ADD: wv = XW'(a_q) + XW'(b_q);
        OP_SUB: wv = XW'(a_q) - XW'(b_q);
        OP_MUL: wv = XW'(prod >>> FRAC);
        OP_DIV: begin  // reaches EXEC only when b == 0
          dbz_w = 1'b1;
          wv    = a_q[WIDTH-1] ? XW'($signed(QMIN)) : XW'($signed(QMAX));
        end
        OP_MOD: begin
          dbz_w = 1'b1;
          wv    = XW'(a_q);
        end
        OP_AND: begin narrow = 1'b1; rw = a_q & b_q; end
        OP_OR:  begin narrow = 1'b1; rw = a_q | b_q; end
        OP_XOR: begin narrow = 1'b1; rw = a_q ^ b_q; end
        OP_SHL: begin narrow = 1'b1; rw = a_q <<  b_q[SHW-1:0]; end
        OP_SHR: begin narrow = 1'b1; rw = a_q >>> b_q[SHW-1:0]; end
        OP_ABS: wv = a_q[WIDTH-1] ? -XW'(a_q) : XW'(a_q);
        OP_NEG: wv = -XW'(a_q);
        OP_CMP: begin
          narrow = 1'b1;
          rw = (a_q > b_q) ? QONE : ((a_q < b_q) ? -QONE : '0);
        end
        OP_MIN: begin narrow = 1'b1; rw = (a_q < b_q) ? a_q : b_q; end
        OP_MAX: begin narrow = 1'b1; rw = (a_q > b_q) ? a_q : b_q; end
        default: ;
      endcase
    end
    if (narrow) wv = XW'(rw);
    // The value fits WIDTH bits only if the upper bits and the WIDTH sign bit all agree.
    ovf_w = !((&wv[XW-1:WIDTH-1]) || !(|wv[XW-1:WIDTH-1]));
    if (ovf_w && (SATURATE != 0)) res_w = wv[XW-1] ? QMIN : QMAX;
    else                          res_w = wv[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = div_start ? S_DIV_ITER : S_EXEC;
      S_EXEC:     state_d = S_HOLD;
      S_DIV_ITER: if (div_done) state_d = S_HOLD;
      S_HOLD:     if (out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        op_q  <= operation;
        a_q   <= operand_a;
        b_q   <= operand_b;
        res_q <= '0;
        ovf_q <= 1'b0;
        dbz_q <= 1'b0;
      end
      if ((state_q == S_EXEC) || ((state_q == S_DIV_ITER) && div_done)) begin
        res_q <= res_w;
        ovf_q <= ovf_w;
        dbz_q <= dbz_w;
      end
    end
  end

endmodule

// File: tb/tb_fixed_alu_gen.sv
module tb_fixed_alu_gen;
  import fixed_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, out_ready;
  logic [3:0]  operation;
  logic [31:0] operand_a, operand_b;
  logic        in_ready, out_valid, overflow, div_by_zero;
  logic [31:0] result;
  logic        in_ready_w, out_valid_w, overflow_w, div_by_zero_w;
  logic [31:0] result_w;

  int n_chk = 0, n_fail = 0;
  int n_in = 0, n_out = 0;

  always #5 clk = ~clk;

  fixed_alu_gen #(.WIDTH(32), .FRAC(14), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  fixed_alu_gen #(.WIDTH(32), .FRAC(14), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
    .overflow(overflow_w), .div_by_zero(div_by_zero_w)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready)   n_in++;
    if (out_valid && out_ready) n_out++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for its result.
  // Consumes the result with a single out_ready pulse.
  // lat counts the acceptance edge as edge 1.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov, output logic dz,
                       output logic [31:0] rw, output logic ovw, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; operation = op; operand_a = a; operand_b = b;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r = result; ov = overflow; dz = div_by_zero; rw = result_w; ovw = overflow_w;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, rw;
    logic        ov, dz, ovw;
    int          lat, in0, out0;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,    0);
    chk("rst_out_valid", out_valid,   0);
    chk("rst_result",    result,      0);
    chk("rst_ovf",       overflow,    0);
    chk("rst_dbz",       div_by_zero, 0);
    chk("rst_wrap_hs",   {in_ready_w, out_valid_w}, 0);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_up", in_ready, 1);

    do_op(OP_MUL, 32'h0000_6000, 32'h0000_8000, r, ov, dz, rw, ovw, lat);
    chk("mul_res", r, 32'h0000_C000); chk("mul_ovf", ov, 0); chk("mul_lat", lat, 2);
    do_op(OP_MUL, 32'hFFFF_C000, 32'h0000_6000, r, ov, dz, rw, ovw, lat);
    chk("mul_neg", r, 32'hFFFF_A000);
    do_op(OP_MUL, 32'hFFFF_FFFF, 32'h0000_2000, r, ov, dz, rw, ovw, lat);
    chk("mul_floor", r, 32'hFFFF_FFFF);

    do_op(OP_DIV, 32'h0000_C000, 32'h0000_8000, r, ov, dz, rw, ovw, lat);
    chk("div_res", r, 32'h0000_6000); chk("div_lat", lat, 48); chk("div_dbz", dz, 0);
    do_op(OP_DIV, 32'hFFFF_4000, 32'h0000_8000, r, ov, dz, rw, ovw, lat);
    chk("div_neg", r, 32'hFFFF_A000);
    do_op(OP_MOD, 32'hFFFF_B000, 32'h0000_3000, r, ov, dz, rw, ovw, lat);
    chk("mod_neg", r, 32'hFFFF_E000); chk("mod_lat", lat, 48);

    do_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_4000, r, ov, dz, rw, ovw, lat);
    chk("add_sat", r, 32'h7FFF_FFFF); chk("add_sat_ovf", ov, 1);
    chk("add_wrap", rw, 32'h8000_3FFF); chk("add_wrap_ovf", ovw, 1);
    do_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, r, ov, dz, rw, ovw, lat);
    chk("sub_sat", r, 32'h8000_0000); chk("sub_wrap", rw, 32'h7FFF_FFFF); chk("sub_ovf", ov, 1);
    do_op(OP_NEG, 32'h8000_0000, 32'h0, r, ov, dz, rw, ovw, lat);
    chk("neg_sat", r, 32'h7FFF_FFFF); chk("neg_ovf", ov, 1); chk("neg_wrap", rw, 32'h8000_0000);
    do_op(OP_ABS, 32'h8000_0000, 32'h0, r, ov, dz, rw, ovw, lat);
    chk("abs_min", {ov, r}, {1'b1, 32'h7FFF_FFFF});

    do_op(OP_DIV, 32'h0000_4000, 32'h0, r, ov, dz, rw, ovw, lat);
    chk("dz_div_res", r, 32'h7FFF_FFFF); chk("dz_div_flag", dz, 1); chk("dz_div_lat", lat, 2);
    do_op(OP_DIV, 32'hFFFF_0000, 32'h0, r, ov, dz, rw, ovw, lat);
    chk("dz_div_negres", r, 32'h8000_0000);
    do_op(OP_MOD, 32'h0000_5000, 32'h0, r, ov, dz, rw, ovw, lat);
    chk("dz_mod_res", r, 32'h0000_5000); chk("dz_mod_flag", dz, 1);
    do_op(OP_ADD, 32'h1, 32'h2, r, ov, dz, rw, ovw, lat);
    chk("flags_clear", {ov, dz, r}, {2'b00, 32'h3});

    do_op(OP_CMP, 32'h1, 32'h2, r, ov, dz, rw, ovw, lat);
    chk("cmp_lt", r, 32'hFFFF_C000);
    do_op(OP_CMP, 32'h5, 32'hFFFF_FFFB, r, ov, dz, rw, ovw, lat);
    chk("cmp_gt", r, 32'h0000_4000);
    do_op(OP_CMP, 32'h7, 32'h7, r, ov, dz, rw, ovw, lat);
    chk("cmp_eq", r, 32'h0);
    do_op(OP_MIN, 32'hFFFF_FFFF, 32'h5, r, ov, dz, rw, ovw, lat);
    chk("min", r, 32'hFFFF_FFFF);
    do_op(OP_MAX, 32'hFFFF_FFFF, 32'h5, r, ov, dz, rw, ovw, lat);
    chk("max", r, 32'h5);
    do_op(OP_SHR, 32'h8000_0000, 32'h4, r, ov, dz, rw, ovw, lat);
    chk("shr_arith", r, 32'hF800_0000);
    do_op(OP_SHL, 32'h4000_0000, 32'h21, r, ov, dz, rw, ovw, lat);
    chk("shl_noovf", {ov, r}, {1'b0, 32'h8000_0000});
    do_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, r, ov, dz, rw, ovw, lat);
    chk("xor", r, 32'hFF00_EDCB);
    do_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, r, ov, dz, rw, ovw, lat);
    chk("and", r, 32'h00F0_1234);
    do_op(4'd15, 32'h1234, 32'h5678, r, ov, dz, rw, ovw, lat);
    chk("undef", {ov, dz, r}, 34'h0);

    // Backpressure: the consumer stalls while a second request waits at the input.
    in0 = n_in; out0 = n_out;
    @(negedge clk);
    in_valid = 1'b1; operation = OP_ADD; operand_a = 32'h4000; operand_b = 32'h4000;
    @(posedge clk); #1;
    operation = OP_SUB; operand_a = 32'h4000; operand_b = 32'h1000;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_result", result, 32'h0000_8000);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_second", result, 32'h0000_3000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_n_in", n_in - in0, 2);
    chk("bp_n_out", n_out - out0, 2);

    // Reset during the divider's iterations.
    @(negedge clk);
    in_valid = 1'b1; operation = OP_DIV; operand_a = 32'h0000_C000; operand_b = 32'h0000_8000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rdiv_out_valid", out_valid, 0);
    chk("rdiv_outputs", {in_ready, overflow, div_by_zero, result}, 35'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset while in HOLD with a nonzero result.
    @(negedge clk);
    in_valid = 1'b1; operation = OP_ADD; operand_a = 32'h4000; operand_b = 32'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rhold_pre", {out_valid, result}, {1'b1, 32'h0000_8000});
    reset_n = 1'b0;
    #1;
    chk("rhold_out_valid", out_valid, 0);
    chk("rhold_result", result, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(OP_ADD, 32'h4000, 32'h4000, r, ov, dz, rw, ovw, lat);
    chk("post_rst_add", {ov, r}, {1'b0, 32'h0000_8000});
    chk("post_rst_lat", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
